rr_slot_arbiter: RTL and testbench
==================================

# rr_slot_arbiter

Round-robin arbiter that shares one downstream resource among N requesters. Priority is held in a one-hot rotating pointer, the same rotate-left structure as our ring counters. The block issues one registered one-hot grant at a time. A grant is held until the owner signals `done`, drops its request, or exceeds a hold limit. It sits between the requesting engines and the shared datapath and sequences access to it.

## Interface
- `N`, 4: number of requesters; N ≥ 2.
- `IDX_W`, 2: width of `grant_idx`; must equal clog2(N).
- `MAX_HOLD`, 16: maximum number of cycles a grant stays asserted. 0 disables the limit. Otherwise 1 ≤ MAX_HOLD ≤ 255.

- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  N  request vector; bit i is asserted by requester i while it wants the resource.
- `done`  in  1  current owner releases the resource; sampled only in GRANT.
- `grant`  out  N  registered one-hot grant; all zero when no owner.
- `grant_idx`  out  IDX_W  binary index of the current owner; holds the last owner while idle.
- `busy`  out  1  high whenever `grant` is nonzero.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- **Reset values:**
  - state = IDLE
  - `grant` = 0, `grant_idx` = 0, `busy` = 0, `timeout` = 0
  - priority pointer `ptr` = one-hot bit 0 (requester 0 has highest priority)
  - hold counter = 0
- **State IDLE:**
  - If `req` is nonzero, select the first set bit of `req` scanning upward from the position of `ptr`, wrapping N-1 → 0.
  - At the edge, load `grant` = one-hot of the winner, `grant_idx` = winner index, hold counter = 1, state → GRANT.
  - `ptr` becomes one-hot of (winner+1) mod N, i.e. winner rotated left with wrap.
  - If `req` = 0, stay in IDLE and leave `ptr` unchanged.
  - `done` is ignored in IDLE.
- **State GRANT, release conditions evaluated at each edge:**
  - (a) `done` = 1: normal release.
  - (b) `req[grant_idx]` = 0: owner withdrew; normal release.
  - (c) MAX_HOLD ≠ 0 and hold counter = MAX_HOLD and neither (a) nor (b): forced release; `timeout` = 1 for the next cycle.
  - On any release: `grant` → 0, `busy` → 0, state → IDLE. `ptr` is not re-advanced.
  - Otherwise the hold counter increments (saturating at 255) and the grant holds.
- **Simultaneous events:**
  - `done` together with a limit hit counts as a normal release; `timeout` stays 0.
  - Changes to non-owner bits of `req` during GRANT have no effect.
- **Fairness:** a continuously requesting agent waits at most N-1 other grants before being served.
- **Reset mid-grant:** `grant` clears immediately (asynchronously), and `ptr` returns to bit 0.
- **Invariant:** `grant` is always zero or one-hot. `busy` equals the OR of `grant`.

## Timing
- **Grant latency:** `req` sampled at edge k in IDLE → `grant` valid after edge k. That is 1 cycle from request to grant.
- **Release latency:** a release condition sampled at edge m → `grant` = 0 after edge m. The owner must treat the grant as lost from that cycle.
- **Turnaround:** the earliest next grant appears after edge m+1. Back-to-back owners are always separated by exactly one idle cycle with `grant` = 0.
- **Timeout timing:** a timed-out grant is asserted for exactly MAX_HOLD cycles. The `timeout` pulse coincides with the first idle cycle.
- **Outputs:** all outputs are registered; there is no combinational path from `req` or `done` to any output.

## Test plan
- **Reset then single request:** release `rst`, hold `req` = 0100 → `grant` = 0100 and `grant_idx` = 2 one cycle later, `busy` = 1. Pulse `done` → `grant` = 0 next cycle.
- **Rotation:** N=4, `req` = 1010 held constant, `done` pulsed one cycle after each grant → grant sequence 0010, 1000, 0010, 1000, with one zero cycle between grants.
- **All requesting:** `req` = 1111 with a release after 2 cycles each → owners in order 0, 1, 2, 3, 0. Each grant lasts 2 cycles.
- **Hold limit:** MAX_HOLD = 4, `req` = 0001 held, `done` = 0 → `grant` = 0001 for exactly 4 cycles, then 0 with `timeout` = 1 for one cycle, then regranted.
- **Simultaneous release:** `done` asserted on the cycle the hold counter reaches 4 → release with `timeout` = 0. Separately, owner drops `req` mid-grant → `grant` = 0 next cycle and `timeout` = 0.
- **Async reset mid-grant:** assert `rst` while `grant` = 1000 → all outputs 0 before the next edge. After release with `req` = 1001, `grant` = 0001.

Source files
------------

// File: rtl/rr_slot_arbiter.sv
// rr_slot_arbiter: round-robin arbiter with a one-hot rotating priority pointer,
// registered one-hot grant, and an optional hold limit that forces a release.
module rr_slot_arbiter #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           r_state, w_nxt_state;
  logic [N-1:0]     r_grant, r_ptr, w_nxt_grant, w_nxt_ptr, w_win_oh;
  logic [IDX_W-1:0] r_idx, w_nxt_idx, w_ptr_idx, w_win;
  logic [IDX_W:0]   w_pos;
  logic [7:0]       r_cnt, w_nxt_cnt;
  logic             r_to, w_nxt_to, w_rel, w_lim;
  // Scan downward in distance so the requester nearest the pointer wins last.
  always_comb begin
    w_ptr_idx = '0;
    for (int i = 0; i < N; i++) w_ptr_idx = r_ptr[i] ? IDX_W'(i) : w_ptr_idx;
    w_win = w_ptr_idx;
    w_pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = {1'b0, w_ptr_idx} + (IDX_W+1)'(k);
      w_pos = (w_pos >= (IDX_W+1)'(N)) ? w_pos - (IDX_W+1)'(N) : w_pos;
      w_win = req[w_pos[IDX_W-1:0]] ? w_pos[IDX_W-1:0] : w_win;
    end
  end
  assign w_win_oh = N'(1) << w_win;
  assign w_rel    = done | ~req[r_idx];
  assign w_lim    = (MAX_HOLD != 0) && (r_cnt == 8'(MAX_HOLD));
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_grant = r_grant;
    w_nxt_idx   = r_idx;
    w_nxt_ptr   = r_ptr;
    w_nxt_cnt   = r_cnt;
    w_nxt_to    = 1'b0;
    if (r_state == IDLE) begin
      if (|req) begin
        w_nxt_state = GRANT;
        w_nxt_grant = w_win_oh;
        w_nxt_idx   = w_win;
        w_nxt_ptr   = {w_win_oh[N-2:0], w_win_oh[N-1]};
        w_nxt_cnt   = 8'd1;
      end
    end else if (w_rel || w_lim) begin
      w_nxt_state = IDLE;
      w_nxt_grant = '0;
      w_nxt_to    = ~w_rel;
    end else begin
      w_nxt_cnt = (r_cnt == 8'hff) ? r_cnt : r_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= N'(1);
      r_cnt   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_grant <= w_nxt_grant;
      r_idx   <= w_nxt_idx;
      r_ptr   <= w_nxt_ptr;
      r_cnt   <= w_nxt_cnt;
      r_to    <= w_nxt_to;
    end
  end
  assign grant     = r_grant;
  assign grant_idx = r_idx;
  assign busy      = |r_grant;
  assign timeout   = r_to;
endmodule

// File: tb/tb_rr_slot_arbiter.sv
// tb_rr_slot_arbiter: directed vector table, hand-written reset sequence, and
// randomized traffic compared against an integer-level reference model.
module tb_rr_slot_arbiter;
  localparam int N = 4;
  localparam int IDX_W = 2;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic done = 1'b0;
  logic [N-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic busy, timeout;

  rr_slot_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .grant_idx(grant_idx), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] grant;
    int           idx;
    logic         to;
  } vec_t;
  vec_t vecs[$];

  int tests = 0;
  int fails = 0;

  int m_owner, m_last, m_ptr, m_hold;
  logic m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic d);
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (r != 0) begin
        for (int k = N - 1; k >= 0; k--)
          if (r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        m_last = m_owner;
        m_hold = 1;
        m_ptr  = (m_owner + 1) % N;
      end
    end else if (d || !r[m_owner]) begin
      m_owner = -1;
    end else if (MAX_HOLD != 0 && m_hold == MAX_HOLD) begin
      m_owner = -1;
      m_to = 1'b1;
    end else if (m_hold < 255) begin
      m_hold++;
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    eg = (m_owner < 0) ? '0 : N'(1) << m_owner;
    chk({tag, "_grant"}, 32'(grant), 32'(eg));
    chk({tag, "_idx"}, 32'(grant_idx), 32'(m_last));
    chk({tag, "_busy"}, 32'(busy), 32'(m_owner >= 0));
    chk({tag, "_timeout"}, 32'(timeout), 32'(m_to));
    chk({tag, "_onehot"}, 32'($countones(grant) <= 1), 32'd1);
  endtask

  // Inputs change mid-low-phase; outputs are read 1 time unit after the edge.
  task automatic step(input logic [N-1:0] r, input logic d);
    req = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic add(input logic [N-1:0] r, input logic d, input logic [N-1:0] g, input int i, input logic t);
    vec_t v;
    v.req = r; v.done = d; v.grant = g; v.idx = i; v.to = t;
    vecs.push_back(v);
  endtask

  initial begin
    add(4'b0100, 0, 4'b0100, 2, 0);
    add(4'b0100, 1, 4'b0000, 2, 0);
    add(4'b1010, 0, 4'b1000, 3, 0);
    add(4'b1010, 1, 4'b0000, 3, 0);
    add(4'b1010, 0, 4'b0010, 1, 0);
    add(4'b1010, 1, 4'b0000, 1, 0);
    add(4'b1010, 0, 4'b1000, 3, 0);
    add(4'b1010, 1, 4'b0000, 3, 0);
    add(4'b1111, 0, 4'b0001, 0, 0);
    add(4'b1111, 0, 4'b0001, 0, 0);
    add(4'b1111, 1, 4'b0000, 0, 0);
    add(4'b1111, 0, 4'b0010, 1, 0);
    add(4'b1111, 0, 4'b0010, 1, 0);
    add(4'b1111, 1, 4'b0000, 1, 0);
    add(4'b1111, 0, 4'b0100, 2, 0);
    add(4'b1111, 0, 4'b0100, 2, 0);
    add(4'b1111, 1, 4'b0000, 2, 0);
    add(4'b1111, 0, 4'b1000, 3, 0);
    add(4'b1111, 0, 4'b1000, 3, 0);
    add(4'b1111, 1, 4'b0000, 3, 0);
    add(4'b0001, 0, 4'b0001, 0, 0);
    add(4'b0001, 0, 4'b0001, 0, 0);
    add(4'b0001, 0, 4'b0001, 0, 0);
    add(4'b0001, 0, 4'b0001, 0, 0);
    add(4'b0001, 0, 4'b0000, 0, 1);
    add(4'b0001, 0, 4'b0001, 0, 0);
    add(4'b0001, 0, 4'b0001, 0, 0);
    add(4'b0001, 0, 4'b0001, 0, 0);
    add(4'b0001, 0, 4'b0001, 0, 0);
    add(4'b0001, 1, 4'b0000, 0, 0);
    add(4'b0001, 0, 4'b0001, 0, 0);
    add(4'b0000, 0, 4'b0000, 0, 0);
    add(4'b0001, 0, 4'b0001, 0, 0);
    add(4'b1111, 0, 4'b0001, 0, 0);
    add(4'b1110, 0, 4'b0000, 0, 0);
    add(4'b0000, 1, 4'b0000, 0, 0);
    add(4'b0000, 0, 4'b0000, 0, 0);

    do_reset();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_idx", 32'(grant_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    foreach (vecs[i]) begin
      step(vecs[i].req, vecs[i].done);
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
      chk($sformatf("vec%0d_idx", i), 32'(grant_idx), 32'(vecs[i].idx));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(|vecs[i].grant));
      chk($sformatf("vec%0d_timeout", i), 32'(timeout), 32'(vecs[i].to));
      @(negedge clk);
    end

    do_reset();
    step(4'b1000, 1'b0);
    chk("async_pre_grant", 32'(grant), 32'b1000);
    @(negedge clk);
    step(4'b1000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_idx", 32'(grant_idx), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(4'b1001, 1'b0);
    chk("post_rst_grant", 32'(grant), 32'b0001);
    check_model("post_rst");
    @(negedge clk);

    do_reset();
    begin
      logic [N-1:0] r;
      logic d;
      r = '0;
      for (int c = 0; c < 800; c++) begin
        if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
        d = ($urandom_range(0, 4) == 0);
        step(r, d);
        check_model("rand");
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
